// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 field widths, constants, rounding/state enums and flag indices
// Purpose : common definitions for the half-precision divider datapath.
// Ports   : none (package).
package fp16_pkg;

    localparam int EXP_W      = 5;
    localparam int FRAC_W     = 10;
    localparam int SIG_W      = FRAC_W + 1;   // significand with hidden one
    localparam int QUOT_W     = 13;           // q[12] has weight 2^0
    localparam int EXP_CALC_W = 7;            // signed working exponent

    localparam logic [15:0] FP16_QNAN   = 16'h7E00;
    localparam logic [14:0] FP16_MAXFIN = 15'h7BFF;
    localparam logic [14:0] FP16_INF    = 15'h7C00;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RP  = 2'b10,
        RM_RN  = 2'b11
    } round_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

    // flags = {invalid, divzero, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIVZERO   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fdiv16_if.sv
// rtl/fdiv16_if.sv - operand/result handshake bundle for the FP16 divider
// Purpose : groups the request (in_*, x, y, roundmode) and response (out_*, result, flags) signals.
// Ports   : master drives operands and out_ready; slave (the divider) drives in_ready and results.
interface fdiv16_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    modport master (
        output in_valid, x, y, roundmode, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, x, y, roundmode, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fp16_classify.sv
// rtl/fp16_classify.sv - combinational FP16 operand classifier
// Purpose : flags zero (subnormals flushed), infinity, NaN and signalling NaN.
// Ports   : mag      - in, 15 - exponent and fraction (sign not needed)
//           is_zero  - out - exponent field zero, so subnormals count as zero
//           is_inf   - out - exponent all ones, fraction zero
//           is_nan   - out - exponent all ones, fraction nonzero
//           is_snan  - out - NaN with the quiet bit (frac[9]) clear
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [14:0] mag,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign exp_f  = mag[14:10];
    assign frac_f = mag[9:0];

    assign is_zero = (exp_f == '0);
    assign is_inf  = (exp_f == '1) && (frac_f == '0);
    assign is_nan  = (exp_f == '1) && (frac_f != '0);
    assign is_snan = is_nan && !frac_f[FRAC_W-1];

endmodule

// File: rtl/fdiv16.sv
// rtl/fdiv16.sv - sequential FP16 divider (radix-2 restoring) behind a valid/ready handshake
// Purpose : result = x / y in IEEE-754 half precision with four rounding modes.
// Ports   : clk   - in  - rising-edge clock
//           reset - in  - asynchronous active-high reset
//           bus   - fdiv16_if.slave: in_valid/in_ready/x/y/roundmode request,
//                   out_valid/out_ready/result/flags response
// Config  : FDIV16_FLAGS_EN - when defined the flags output is computed, otherwise tied to 0.
module fdiv16
    import fp16_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    fdiv16_if.slave bus
);

    logic zero_x, inf_x, nan_x, snan_x;
    logic zero_y, inf_y, nan_y, snan_y;

    fp16_classify u_cls_x (
        .mag     (bus.x[14:0]),
        .is_zero (zero_x),
        .is_inf  (inf_x),
        .is_nan  (nan_x),
        .is_snan (snan_x)
    );

    fp16_classify u_cls_y (
        .mag     (bus.y[14:0]),
        .is_zero (zero_y),
        .is_inf  (inf_y),
        .is_nan  (nan_y),
        .is_snan (snan_y)
    );

    div_state_e                   state_q;
    logic [3:0]                   cnt_q;
    logic [QUOT_W-1:0]            quot_q;
    logic [SIG_W:0]               rem_q;
    logic [SIG_W-1:0]             dvsr_q;
    logic signed [EXP_CALC_W-1:0] exp_q;
    logic                         sign_q;
    round_mode_e                  mode_q;
    logic [15:0]                  result_q;
    logic                         in_ready_q;
    logic                         out_valid_q;

    // Special-case detection on the live operands; only used on the accept edge.
    logic        sign_in;
    logic        special;
    logic [15:0] spec_res;
    logic [4:0]  spec_flg;

    assign sign_in = bus.x[15] ^ bus.y[15];

    always_comb begin
        special  = 1'b1;
        spec_res = FP16_QNAN;
        spec_flg = '0;
        if (nan_x || nan_y || (zero_x && zero_y) || (inf_x && inf_y)) begin
            spec_res = FP16_QNAN;
            spec_flg[FLAG_INVALID] = snan_x | snan_y | (zero_x & zero_y) | (inf_x & inf_y);
        end else if (zero_y) begin
            spec_res = {sign_in, FP16_INF};
            spec_flg[FLAG_DIVZERO] = 1'b1;
        end else if (inf_x) begin
            spec_res = {sign_in, FP16_INF};
        end else if (inf_y || zero_x) begin
            spec_res = {sign_in, 15'h0000};
        end else begin
            special = 1'b0;
        end
    end

    // One restoring step. The partial remainder always stays below twice the
    // divisor, so the 11-bit difference is exact whenever rem >= divisor.
    logic             rem_ge;
    logic [SIG_W-1:0] rem_sub;

    assign rem_ge  = (rem_q >= {1'b0, dvsr_q});
    assign rem_sub = rem_q[SIG_W-1:0] - dvsr_q;

    // Normalisation and rounding of the finished quotient.
    logic [FRAC_W-1:0]            frac_pre;
    logic                         guard;
    logic                         sticky;
    logic                         inc;
    logic [FRAC_W:0]              frac_sum;
    logic signed [EXP_CALC_W-1:0] e_pre;
    logic signed [EXP_CALC_W-1:0] e_fin;
    logic [15:0]                  rnd_res;
    logic [4:0]                   rnd_flg;

    always_comb begin
        if (quot_q[QUOT_W-1]) begin
            frac_pre = quot_q[11:2];
            guard    = quot_q[1];
            sticky   = quot_q[0] | (rem_q != '0);
            e_pre    = exp_q + 7'sd15;
        end else begin
            frac_pre = quot_q[10:1];
            guard    = quot_q[0];
            sticky   = (rem_q != '0);
            e_pre    = exp_q + 7'sd14;
        end

        case (mode_q)
            RM_RNE:  inc = guard & (sticky | frac_pre[0]);
            RM_RP:   inc = (guard | sticky) & ~sign_q;
            RM_RN:   inc = (guard | sticky) & sign_q;
            default: inc = 1'b0;
        endcase

        // A carry out leaves frac_sum[9:0] at zero, which is the required fraction.
        frac_sum = {1'b0, frac_pre} + {{FRAC_W{1'b0}}, inc};
        e_fin    = frac_sum[FRAC_W] ? e_pre + 7'sd1 : e_pre;

        rnd_res = {sign_q, e_fin[4:0], frac_sum[FRAC_W-1:0]};
        rnd_flg = '0;
        rnd_flg[FLAG_INEXACT] = guard | sticky;

        if (e_fin >= 7'sd31) begin
            case (mode_q)
                RM_RNE:  rnd_res = {sign_q, FP16_INF};
                RM_RP:   rnd_res = sign_q ? {1'b1, FP16_MAXFIN} : {1'b0, FP16_INF};
                RM_RN:   rnd_res = sign_q ? {1'b1, FP16_INF} : {1'b0, FP16_MAXFIN};
                default: rnd_res = {sign_q, FP16_MAXFIN};
            endcase
            rnd_flg[FLAG_OVERFLOW] = 1'b1;
            rnd_flg[FLAG_INEXACT]  = 1'b1;
        end else if (e_fin <= 7'sd0) begin
            rnd_res = {sign_q, 15'h0000};
            rnd_flg[FLAG_UNDERFLOW] = 1'b1;
            rnd_flg[FLAG_INEXACT]   = 1'b1;
        end
    end

`ifdef FDIV16_FLAGS_EN
    logic [4:0] flags_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            mode_q      <= RM_RZ;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FDIV16_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (special) begin
                            result_q    <= spec_res;
`ifdef FDIV16_FLAGS_EN
                            flags_q     <= spec_flg;
`endif
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            sign_q  <= sign_in;
                            mode_q  <= round_mode_e'(bus.roundmode);
                            exp_q   <= {2'b00, bus.x[14:10]} - {2'b00, bus.y[14:10]};
                            rem_q   <= {2'b01, bus.x[9:0]};
                            dvsr_q  <= {1'b1, bus.y[9:0]};
                            quot_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (rem_ge) begin
                        rem_q  <= {rem_sub, 1'b0};
                        quot_q <= {quot_q[QUOT_W-2:0], 1'b1};
                    end else begin
                        rem_q  <= {rem_q[SIG_W-1:0], 1'b0};
                        quot_q <= {quot_q[QUOT_W-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(QUOT_W - 1)) begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    result_q    <= rnd_res;
`ifdef FDIV16_FLAGS_EN
                    flags_q     <= rnd_flg;
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

`ifdef FDIV16_FLAGS_EN
    assign bus.flags = flags_q;
`else
    assign bus.flags = '0;
    logic unused_flag_terms;
    assign unused_flag_terms = ^{spec_flg, rnd_flg};
`endif

endmodule

// File: tb/tb_fdiv16.sv
// tb/tb_fdiv16.sv - scoreboard bench for fdiv16: directed vectors plus randomized operands
module tb_fdiv16;

    localparam logic [4:0] F_IX  = 5'b00001;
    localparam logic [4:0] F_UF  = 5'b00010;
    localparam logic [4:0] F_OV  = 5'b00100;
    localparam logic [4:0] F_DZ  = 5'b01000;
    localparam logic [4:0] F_INV = 5'b10000;
`ifdef FDIV16_FLAGS_EN
    localparam logic [4:0] FLAG_MASK = 5'h1f;
`else
    localparam logic [4:0] FLAG_MASK = 5'h00;
`endif

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        bit          special;
    } ref_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   stall_left = 0;
    bit   mon_seen   = 1'b0;
    exp_t sb[$];

    fdiv16_if bus();

    fdiv16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer long division of the significands, then the rounding rules.
    function automatic ref_t ref_div(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
        ref_t r;
        int   ea, eb, fa, fb, ma, mb, q, rem, e, frac, g, st, inc;
        bit   sgn, az, ai, an, asn, bz, bi, bn, bsn;
        sgn = a[15] ^ b[15];
        ea = int'(a[14:10]); fa = int'(a[9:0]);
        eb = int'(b[14:10]); fb = int'(b[9:0]);
        az = (ea == 0); ai = (ea == 31 && fa == 0); an = (ea == 31 && fa != 0); asn = an && (fa < 512);
        bz = (eb == 0); bi = (eb == 31 && fb == 0); bn = (eb == 31 && fb != 0); bsn = bn && (fb < 512);
        r.special = 1'b1;
        r.flg = 5'b0;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r.res = 16'h7E00;
            if (asn || bsn || (az && bz) || (ai && bi)) r.flg = F_INV;
            return r;
        end
        if (bz) begin r.res = {sgn, 15'h7C00}; r.flg = F_DZ; return r; end
        if (ai) begin r.res = {sgn, 15'h7C00}; return r; end
        if (bi || az) begin r.res = {sgn, 15'h0000}; return r; end
        r.special = 1'b0;
        ma  = 1024 + fa;
        mb  = 1024 + fb;
        q   = (ma * 4096) / mb;
        rem = (ma * 4096) % mb;
        e   = ea - eb + 14;
        if (q >= 4096) begin
            frac = (q / 4) % 1024; g = (q / 2) % 2; st = ((q % 2) != 0 || rem != 0) ? 1 : 0; e = e + 1;
        end else begin
            frac = (q / 2) % 1024; g = q % 2; st = (rem != 0) ? 1 : 0;
        end
        case (rm)
            2'b01:   inc = (g == 1 && (st == 1 || frac % 2 == 1)) ? 1 : 0;
            2'b10:   inc = ((g | st) == 1 && !sgn) ? 1 : 0;
            2'b11:   inc = ((g | st) == 1 && sgn) ? 1 : 0;
            default: inc = 0;
        endcase
        frac = frac + inc;
        if (frac == 1024) begin frac = 0; e = e + 1; end
        if (e >= 31) begin
            r.flg = F_OV | F_IX;
            case (rm)
                2'b01:   r.res = {sgn, 15'h7C00};
                2'b10:   r.res = sgn ? 16'hFBFF : 16'h7C00;
                2'b11:   r.res = sgn ? 16'hFC00 : 16'h7BFF;
                default: r.res = {sgn, 15'h7BFF};
            endcase
        end else if (e <= 0) begin
            r.flg = F_UF | F_IX;
            r.res = {sgn, 15'h0000};
        end else begin
            r.flg = (g | st) != 0 ? F_IX : 5'b0;
            r.res = {sgn, 5'(e), 10'(frac)};
        end
        return r;
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                         input logic [15:0] eres, input logic [4:0] eflg, input int lat);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.x         = a;
        bus.y         = b;
        bus.roundmode = rm;
        while (!bus.in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", waited, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        chk("accept_while_pending", sb.size(), 0);
        e.res = eres;
        e.flg = eflg & FLAG_MASK;
        e.lat = lat;
        e.acc = cyc;
        sb.push_back(e);
        // Operands are scrambled after accept; the captured values must be used.
        bus.in_valid  = 1'b0;
        bus.x         = 16'($urandom);
        bus.y         = 16'($urandom);
        bus.roundmode = 2'($urandom);
    endtask

    function automatic logic [15:0] rand_fp();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 7) != 0) v[14:10] = 5'($urandom_range(8, 22));
        return v;
    endfunction

    task automatic rand_op();
        logic [15:0] a, b;
        logic [1:0]  rm;
        ref_t        r;
        a  = rand_fp();
        b  = rand_fp();
        rm = 2'($urandom);
        r  = ref_div(a, b, rm);
        do_op(a, b, rm, r.res, r.flg, r.special ? 1 : 15);
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.out_ready = 1'b0;
            end else if (bus.out_valid) begin
                chk("in_ready_while_busy", bus.in_ready, 0);
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    if (!mon_seen) begin
                        chk("latency", cyc - sb[0].acc + 1, sb[0].lat);
                        mon_seen = 1'b1;
                    end
                    chk("result", bus.result, sb[0].res);
                    chk("flags", bus.flags, sb[0].flg);
                    if (stall_left > 0) begin
                        stall_left--;
                        bus.out_ready = 1'b0;
                    end else begin
                        bus.out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        mon_seen = 1'b0;
                    end
                end
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.roundmode = '0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", bus.flags, 0);
        #2 reset = 1'b0;

        do_op(16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'b0, 15);
        do_op(16'h3C00, 16'h4200, 2'b01, 16'h3555, F_IX, 15);
        do_op(16'h3C00, 16'h4200, 2'b00, 16'h3555, F_IX, 15);
        do_op(16'h3C00, 16'h4200, 2'b10, 16'h3556, F_IX, 15);
        do_op(16'h3C00, 16'h0000, 2'b01, 16'h7C00, F_DZ, 1);
        do_op(16'h0000, 16'h0000, 2'b01, 16'h7E00, F_INV, 1);
        do_op(16'h7D00, 16'h3C00, 2'b01, 16'h7E00, F_INV, 1);
        do_op(16'h7BFF, 16'h2C00, 2'b01, 16'h7C00, F_OV | F_IX, 15);
        do_op(16'h7BFF, 16'h2C00, 2'b00, 16'h7BFF, F_OV | F_IX, 15);
        do_op(16'hFBFF, 16'h2C00, 2'b11, 16'hFC00, F_OV | F_IX, 15);
        do_op(16'hFBFF, 16'h2C00, 2'b10, 16'hFBFF, F_OV | F_IX, 15);
        do_op(16'h0400, 16'h4000, 2'b01, 16'h0000, F_UF | F_IX, 15);

        // Backpressure: second request held while the first result stalls.
        stall_left = 5;
        do_op(16'h4000, 16'h3C00, 2'b01, 16'h4000, 5'b0, 15);
        do_op(16'h4400, 16'h4000, 2'b01, 16'h4000, 5'b0, 15);

        // Reset in the middle of DIV aborts the operation.
        do_op(16'h3C00, 16'h4200, 2'b01, 16'h3555, F_IX, 15);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        mon_seen   = 1'b0;
        stall_left = 0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        #2 reset = 1'b0;
        do_op(16'h4400, 16'h4000, 2'b01, 16'h4000, 5'b0, 15);

        for (int i = 0; i < 300; i++) rand_op();

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fdiv16.md
# fdiv16

Sequential IEEE-754 half-precision divider: result = x / y. It is the inverse companion to the `fma16` datapath: `fma16` multiplies, this block divides, and both share the same 16-bit operand format and 2-bit rounding-mode encoding. The quotient comes from a radix-2 restoring significand iteration behind a valid/ready handshake, so it can sit next to `fma16` in the FP execution cluster.

## Interface
- No parameters; operand width is fixed at 16 bits.
- `clk` – input – 1 – rising-edge clock.
- `reset` – input – 1 – asynchronous, active-high reset.
- `in_valid` – input – 1 – operands valid.
- `in_ready` – output – 1 – block idle and able to accept.
- `x` – input – 16 – dividend (FP16).
- `y` – input – 16 – divisor (FP16).
- `roundmode` – input – 2 – rounding mode: 00 rz, 01 rne, 10 rp, 11 rn.
- `out_valid` – output – 1 – result valid.
- `out_ready` – input – 1 – consumer accepts the result.
- `result` – output – 16 – quotient (FP16).
- `flags` – output – 5 – {invalid, divzero, overflow, underflow, inexact}.

## Operation
- Accept occurs on a clock edge where `in_valid && in_ready`. `x`, `y` and `roundmode` are captured at that edge; later input changes are ignored.
- States:
  - IDLE: `in_ready=1`. On accept, go to DONE if the operands are a special case, else go to DIV.
  - DIV: 13 iterations, one quotient bit per cycle, then go to ROUND.
  - ROUND: one cycle, then go to DONE.
  - DONE: `out_valid=1`. When `out_ready` is high, go to IDLE.
- `in_ready` is high only in IDLE. There is no accept in DONE, even if `out_ready` is high.
- Subnormal inputs are flushed to signed zero before classification.
- Special cases (checked in this order):
  - Either operand NaN, 0/0, or inf/inf → `0x7E00`. `invalid` is set for 0/0, for inf/inf, and for any sNaN input (frac≠0 and frac[9]=0).
  - Finite nonzero / 0 → signed inf, `divzero` set.
  - inf / finite → signed inf.
  - finite / inf → signed zero.
  - 0 / nonzero finite → signed zero.
- Normal path:
  - sign = x[15]^y[15].
  - Significands are {1,frac} (11 bits). DIV produces q[12:0], with q[12] having weight 2^0.
  - If q[12]=1: fraction = q[11:2], guard = q[1], sticky = q[0] | (rem≠0). e = ex − ey + 15.
  - If q[12]=0: fraction = q[10:1], guard = q[0], sticky = (rem≠0). e = ex − ey + 14.
  - The exponent is computed as a 7-bit signed value.
- Rounding:
  - rne: increment when guard & (sticky | lsb).
  - rz: never increment.
  - rp: increment when (guard|sticky) & sign=0.
  - rn: increment when (guard|sticky) & sign=1.
  - If the increment carries out of the fraction, the fraction becomes 0 and e increments.
  - `inexact` = guard | sticky.
- Overflow (e ≥ 31): set `overflow` and `inexact`. Result by mode:
  - rne → signed inf.
  - rz → signed `0x7BFF`.
  - rp → `0x7C00` if positive, `0xFBFF` if negative.
  - rn → `0xFC00` if negative, `0x7BFF` if positive.
- Underflow (e ≤ 0 after rounding): result is signed zero; set `underflow` and `inexact`.

## Timing
- Reset values (async, and held during reset): state IDLE, `in_ready=1`, `out_valid=0`, `result=0x0000`, `flags=0`.
- Normal operands: accept at edge 0 → DIV at edges 1..13 → ROUND at edge 14 → `out_valid` high from edge 15.
- Special operands: `out_valid` high from edge 1.
- `result` and `flags` are registered. They stay stable while `out_valid && !out_ready`, for any length of stall.
- The earliest next accept is the cycle after the output handshake.
- Reset asserted mid-operation aborts it immediately; no partial result is ever presented.

## Configuration
- `FDIV16_FLAGS_EN` defined: the `flags` output is computed as specified above.
- `FDIV16_FLAGS_EN` undefined: the flag logic is removed; the `flags` port is kept and driven to 0. `result` is unchanged in both cases.

## Structure
- Package `fp16_pkg`:
  - field-width localparams;
  - `FP16_QNAN=16'h7E00`, `FP16_MAXFIN=15'h7BFF`, `FP16_INF=15'h7C00`;
  - rounding-mode enum;
  - divider state enum;
  - flag-index constants.
- Sub-module `fp16_classify` (combinational, instantiated for `x` and `y`): outputs is_zero (including flushed subnormals), is_inf, is_nan, is_snan.

## Test plan
- x=`0x4000`, y=`0x3C00`, rne → `0x4000`, flags=0; `out_valid` exactly 15 cycles after accept.
- x=`0x3C00`, y=`0x4200`: rne → `0x3555`; rz → `0x3555`; rp → `0x3556`. `inexact` set in all three modes.
- Special cases (`out_valid` 1 cycle after accept):
  - x=`0x3C00`, y=`0x0000` → `0x7C00` with `divzero`.
  - x=`0x0000`, y=`0x0000` → `0x7E00` with `invalid`.
  - x=`0x7D00` (sNaN), y=`0x3C00` → `0x7E00` with `invalid`.
- Range limits:
  - x=`0x7BFF`, y=`0x2C00`: rne → `0x7C00`; rz → `0x7BFF`. Both set `overflow|inexact`.
  - x=`0x0400`, y=`0x4000` → `0x0000` with `underflow|inexact`.
- Backpressure: hold `out_ready=0` for 5 cycles with `in_valid=1` → `result` stable, `in_ready=0`, no second accept until the handshake completes.
- Reset pulse at edge 6 of DIV → `out_valid=0`, `in_ready=1`. The next operation x=`0x4400`, y=`0x4000` returns `0x4000`.
